// File: rtl/counter_sequencer.sv
// counter_sequencer: accepts load/count commands, drives a 3-bit counter,
// verifies its value afterwards and raises a sticky fault on mismatch or counter error.
module counter_sequencer #(
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [2:0]        cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              ctr_ld,
  output logic              ctr_inc,
  output logic [2:0]        ctr_data,
  input  logic [2:0]        ctr_value,
  input  logic              ctr_error,
  output logic              done,
  output logic              fault,
  output logic [2:0]        result
);
  typedef enum logic [2:0] {IDLE, LOAD, COUNT, VERIFY, DONE, FAULT} state_t;
  state_t state, state_n;
  logic [STEP_W-1:0] remaining;
  logic [2:0] expected;
  logic accept;
  assign accept = cmd_valid & cmd_ready;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = !cmd_op ? LOAD : (cmd_steps != '0 ? COUNT : DONE);
      LOAD:    state_n = VERIFY;
      COUNT:   if (remaining == STEP_W'(1)) state_n = VERIFY;
      VERIFY:  state_n = ctr_value == expected ? DONE : FAULT;
      DONE:    state_n = IDLE;
      default: state_n = FAULT;
    endcase
    // a counter error beats every other transition, including a same-cycle accept
    if (ctr_error) state_n = FAULT;
  end
  // outputs are registered alongside the state so nothing reaches them combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      ctr_ld    <= 1'b0;
      ctr_inc   <= 1'b0;
      ctr_data  <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      result    <= '0;
      remaining <= '0;
      expected  <= '0;
    end else begin
      state     <= state_n;
      cmd_ready <= state_n == IDLE;
      ctr_ld    <= state_n == LOAD;
      ctr_inc   <= state_n == COUNT;
      ctr_data  <= state_n == LOAD ? cmd_data : '0;
      done      <= state_n == DONE;
      fault     <= state_n == FAULT;
      if (state_n == DONE) result <= ctr_value;
      if (accept) begin
        expected  <= cmd_op ? ctr_value + cmd_steps[2:0] : cmd_data;
        remaining <= cmd_steps;
      end else if (state == COUNT) remaining <= remaining - STEP_W'(1);
    end
  end
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller that sequences the three-bit counter in the chapter 9 design. It accepts load/count commands over a valid/ready handshake and drives the counter's `ld`/`inc`/`data_in` inputs. It then checks the counter's `data_out` against an internal expected value and monitors the counter's `error` flag. It reports completion with a one-cycle `done` pulse, and reports any mismatch or error with a sticky `fault`.

## Interface
- `STEP_W`, default 4: width of `cmd_steps`; at most 2^STEP_W-1 increments per command.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept; high only in IDLE.
- `cmd_op`  in  1  0 = load, 1 = count.
- `cmd_data`  in  3  load value; ignored for count.
- `cmd_steps`  in  STEP_W  number of increments for count; ignored for load.
- `ctr_ld`  out  1  to counter `ld`.
- `ctr_inc`  out  1  to counter `inc`.
- `ctr_data`  out  3  to counter `data_in`.
- `ctr_value`  in  3  from counter `data_out`.
- `ctr_error`  in  1  from counter `error`.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  sticky fault flag; cleared only by `rst`.
- `result`  out  3  counter value captured at verify; holds until next completion.

## Operation
- Accept occurs when `cmd_valid & cmd_ready` is high at a posedge. On accept, latch op, data and steps.
- For count commands, the accept edge also sets `expected = (ctr_value + cmd_steps) mod 8`, truncated to 3 bits.
- For load commands, `expected = cmd_data`.
- State machine states: IDLE, LOAD, COUNT, VERIFY, DONE, FAULT.
- IDLE: `cmd_ready=1`.
  - Accepted load -> LOAD.
  - Accepted count with steps>0 -> COUNT.
  - Accepted count with steps==0 -> DONE, with `result` = current `ctr_value`.
- LOAD: `ctr_ld=1` and `ctr_data` = latched data for exactly one cycle -> VERIFY.
- COUNT: `ctr_inc=1`. The remaining-steps counter decrements each cycle. On the cycle where remaining==1 -> VERIFY.
- VERIFY: compare `ctr_value` with `expected`.
  - Equal: capture `result`, then -> DONE.
  - Unequal: -> FAULT.
- DONE: `done=1` for one cycle -> IDLE.
- FAULT: `fault=1`, `cmd_ready=0`, all counter controls low. Stays in FAULT until `rst`.
- If `ctr_error` is sampled high in any state other than FAULT, the next state is FAULT. This overrides all other transitions, including an accept in the same cycle.
- `ctr_ld` and `ctr_inc` are never asserted together.
- `ctr_data` is 0 whenever `ctr_ld` is 0.
- Counter wrap (7 -> 0) is legal. The expected value uses mod-8 arithmetic.
- The sequencer does not reset the counter. The counter's own reset is driven separately.

## Timing
- Accept at edge T means the command was presented in cycle T-1 and is sampled on edge T.
- Load: `ctr_ld` high in cycle T+1, VERIFY in T+2, `done` in T+3. Latency is 3 cycles.
- Count N (N≥1): `ctr_inc` high in cycles T+1..T+N, VERIFY in T+N+1, `done` in T+N+2.
- Count 0: `done` in T+1. No `ctr_inc` pulse.
- The next command can be accepted on the edge after the DONE cycle. With `cmd_valid` held high, the gap between `done` and the next accept is 1 cycle.
- Reset, after any posedge with `rst=1`:
  - state = IDLE
  - `cmd_ready=1`
  - `ctr_ld=0`, `ctr_inc=0`, `ctr_data=0`
  - `done=0`, `fault=0`, `result=0`
- Reset mid-operation: `ctr_ld`/`ctr_inc` drop on the next edge. No `done` is issued and the command is discarded.
- Reset dominates `ctr_error` and `cmd_valid` in the same cycle.
- All outputs are decoded from registered state (Moore). There is no combinational path from inputs to outputs.

## Test plan
- Reset, then load 5:
  - `ctr_ld` is high for exactly 1 cycle with `ctr_data=5`.
  - `done` fires at T+3 with `result=5`; `fault=0`.
- Counter at 5, count 3:
  - `ctr_inc` is high for 3 cycles.
  - `done` fires at T+5 with `result=0` (wrap).
- Count with `cmd_steps=0` while counter=2:
  - `done` fires at T+1 with `result=2`.
  - No `ctr_inc` or `ctr_ld` activity.
- `ctr_error` pulsed for 1 cycle during the 2nd cycle of a 6-step count:
  - `ctr_inc` drops next cycle and `fault=1`.
  - `cmd_ready=0` persists with `cmd_valid` held high, and no `done` fires.
  - After `rst`, `fault=0` and `cmd_ready=1`.
- Stuck counter model (`ctr_value` fixed at 2), load 6:
  - VERIFY mismatch leads to FAULT at T+3.
  - `done` never fires and `result` stays at its prior value.
- `rst` asserted at cycle T+2 of a 7-step count:
  - `ctr_inc` is low from T+3 and no `done` fires.
  - `cmd_ready=1` after reset; a new load 4 completes normally.
